// File: rtl/exe_stage_pkg.sv
// exe_stage shared definitions: bus widths, SRAM size codes, ALU op bit
// indices and the request-tracking state type.
// Optional multiplier support is selected with the EXE_MUL_EN macro.
package exe_stage_pkg;

`ifdef EXE_MUL_EN
    localparam int unsigned ALU_OP_W            = 15;
    localparam int unsigned ID_TO_EXE_BUS_WIDTH = 157;
`else
    localparam int unsigned ALU_OP_W            = 12;
    localparam int unsigned ID_TO_EXE_BUS_WIDTH = 154;
`endif
    localparam int unsigned EXE_TO_MEM_BUS_WIDTH = 110;
    localparam int unsigned EXE_TO_ID_BUS_WIDTH  = 40;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    // alu_op one-hot bit positions
    localparam int unsigned OP_ADD   = 0;
    localparam int unsigned OP_SUB   = 1;
    localparam int unsigned OP_SLT   = 2;
    localparam int unsigned OP_SLTU  = 3;
    localparam int unsigned OP_AND   = 4;
    localparam int unsigned OP_OR    = 5;
    localparam int unsigned OP_NOR   = 6;
    localparam int unsigned OP_XOR   = 7;
    localparam int unsigned OP_SLL   = 8;
    localparam int unsigned OP_SRL   = 9;
    localparam int unsigned OP_SRA   = 10;
    localparam int unsigned OP_LUI   = 11;
    localparam int unsigned OP_MUL   = 12;
    localparam int unsigned OP_MULH  = 13;
    localparam int unsigned OP_MULHU = 14;

    typedef enum logic {
        REQ_IDLE   = 1'b0,
        REQ_ISSUED = 1'b1
    } req_state_t;

    // Byte strobes for a store of the given size at the given low address bits
    function automatic logic [3:0] store_strobe(input logic       wr,
                                                input logic [1:0] size,
                                                input logic [1:0] addr_lo);
        logic [3:0] strb;
        strb = '0;
        if (wr) begin
            if (size == SIZE_BYTE) strb = 4'b0001 << addr_lo;
            else                   strb = 4'b1111;
        end
        return strb;
    endfunction

endpackage

// File: rtl/exe_stage_alu.sv
// Combinational integer ALU for the execute stage (12 one-hot ops).
// Multiply ops, when built with EXE_MUL_EN, are handled by exe_mul.
module alu
    import exe_stage_pkg::*;
(
    input  logic [11:0] alu_op,
    input  logic [31:0] alu_src1,
    input  logic [31:0] alu_src2,
    output logic [31:0] alu_result
);
    logic [4:0] sh;
    assign sh = alu_src2[4:0];

    // OR together the single selected op's result
    always_comb begin
        alu_result = '0;
        if (alu_op[OP_ADD])  alu_result = alu_result | (alu_src1 + alu_src2);
        if (alu_op[OP_SUB])  alu_result = alu_result | (alu_src1 - alu_src2);
        if (alu_op[OP_SLT])  alu_result = alu_result | {31'b0, $signed(alu_src1) < $signed(alu_src2)};
        if (alu_op[OP_SLTU]) alu_result = alu_result | {31'b0, alu_src1 < alu_src2};
        if (alu_op[OP_AND])  alu_result = alu_result | (alu_src1 & alu_src2);
        if (alu_op[OP_OR])   alu_result = alu_result | (alu_src1 | alu_src2);
        if (alu_op[OP_NOR])  alu_result = alu_result | ~(alu_src1 | alu_src2);
        if (alu_op[OP_XOR])  alu_result = alu_result | (alu_src1 ^ alu_src2);
        if (alu_op[OP_SLL])  alu_result = alu_result | (alu_src1 << sh);
        if (alu_op[OP_SRL])  alu_result = alu_result | (alu_src1 >> sh);
        if (alu_op[OP_SRA])  alu_result = alu_result | 32'($signed(alu_src1) >>> sh);
        if (alu_op[OP_LUI])  alu_result = alu_result | alu_src2;
    end

endmodule

// File: rtl/exe_stage_mul.sv
// Two-cycle 32x32 multiplier for mul/mulh/mulhu; only built with EXE_MUL_EN.
// Product is captured on the first EXE cycle; done rises on the second.
`ifdef EXE_MUL_EN
module exe_mul (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        start,
    input  logic        lo_sel,
    input  logic        signed_op,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    output logic        done,
    output logic [31:0] result
);
    logic        cnt;
    logic [63:0] prod_q;
    logic [63:0] ext1;
    logic [63:0] ext2;

    assign ext1 = {{32{signed_op & src1[31]}}, src1};
    assign ext2 = {{32{signed_op & src2[31]}}, src2};

    // one-bit cycle counter, cleared whenever a new instruction enters EXE
    always_ff @(posedge clk) begin
        if (reset || flush)     cnt <= 1'b0;
        else if (start && !cnt) cnt <= 1'b1;
    end

    // capture the product once per instruction
    always_ff @(posedge clk) begin
        if (start && !cnt) prod_q <= ext1 * ext2;
    end

    assign done   = cnt;
    assign result = lo_sel ? prod_q[31:0] : prod_q[63:32];

endmodule
`endif

// File: rtl/exe_stage.sv
// Execute stage: ALU, data-SRAM request phase (req/addr_ok), EXE->MEM bus
// and EXE->ID forwarding bus. EXE_MUL_EN adds a two-cycle multiplier.
module exe_stage
    import exe_stage_pkg::*;
#(
    parameter int unsigned ID_TO_EXE_W  = ID_TO_EXE_BUS_WIDTH,
    parameter int unsigned EXE_TO_MEM_W = EXE_TO_MEM_BUS_WIDTH,
    parameter int unsigned EXE_TO_ID_W  = EXE_TO_ID_BUS_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    output logic                    exe_allow_in,
    input  logic                    id_to_exe_valid,
    input  logic                    mem_allow_in,
    output logic                    exe_to_mem_valid,
    input  logic [ID_TO_EXE_W-1:0]  id_to_exe_bus,
    output logic [EXE_TO_MEM_W-1:0] exe_to_mem_bus,
    output logic [EXE_TO_ID_W-1:0]  exe_to_id_bus,
    output logic                    data_sram_req,
    output logic                    data_sram_wr,
    output logic [1:0]              data_sram_size,
    output logic [3:0]              data_sram_wstrb,
    output logic [31:0]             data_sram_addr,
    output logic [31:0]             data_sram_wdata,
    input  logic                    data_sram_addr_ok
);
    logic                   exe_valid;
    logic                   exe_ready_go;
    logic                   mem_ready_go;
    logic                   load_en;
    logic [ID_TO_EXE_W-1:0] exe_reg;
    req_state_t             req_state;
    req_state_t             req_state_n;
    logic                   req_done;

    logic [31:0]         e_pc;
    logic [ALU_OP_W-1:0] e_alu_op;
    logic [31:0]         e_src1;
    logic [31:0]         e_src2;
    logic [31:0]         e_rkd;
    logic                e_res_from_mem;
    logic                e_reg_we;
    logic                e_mem_en;
    logic [3:0]          e_mem_we;
    logic [4:0]          e_reg_waddr;
    logic [1:0]          e_size;

    logic [31:0] alu_out;
    logic [31:0] alu_result;
    logic        is_mul;

    assign {e_pc, e_alu_op, e_src1, e_src2, e_rkd, e_res_from_mem, e_reg_we,
            e_mem_en, e_mem_we, e_reg_waddr, e_size} = exe_reg;

    assign load_en          = exe_allow_in && id_to_exe_valid;
    assign exe_allow_in     = !exe_valid || (exe_ready_go && mem_allow_in);
    assign exe_to_mem_valid = exe_valid && exe_ready_go;

    // stage valid bit
    always_ff @(posedge clk) begin
        if (reset)             exe_valid <= 1'b0;
        else if (exe_allow_in) exe_valid <= id_to_exe_valid;
    end

    // instruction payload, captured only on accept
    always_ff @(posedge clk) begin
        if (load_en) exe_reg <= id_to_exe_bus;
    end

    alu u_alu (
        .alu_op     (e_alu_op[11:0]),
        .alu_src1   (e_src1),
        .alu_src2   (e_src2),
        .alu_result (alu_out)
    );

    // request is gated on mem_allow_in so MEM can always latch before data_ok
    assign data_sram_req   = exe_valid && e_mem_en && !req_done && mem_allow_in;
    assign data_sram_wr    = |e_mem_we;
    assign data_sram_size  = e_size;
    assign data_sram_addr  = alu_result;
    assign data_sram_wstrb = store_strobe(data_sram_wr, e_size, alu_result[1:0]);
    assign data_sram_wdata = (e_size == SIZE_BYTE) ? {4{e_rkd[7:0]}} : e_rkd;

    assign req_done     = (req_state == REQ_ISSUED);
    assign mem_ready_go = !e_mem_en || (data_sram_req && data_sram_addr_ok) || req_done;

    // request-issued state register
    always_ff @(posedge clk) begin
        if (reset) req_state <= REQ_IDLE;
        else       req_state <= req_state_n;
    end

    // request-issued next state
    always_comb begin
        req_state_n = req_state;
        if (load_en)
            req_state_n = REQ_IDLE;
        else if (req_state == REQ_IDLE && data_sram_req && data_sram_addr_ok && !mem_allow_in)
            req_state_n = REQ_ISSUED;
    end

`ifdef EXE_MUL_EN
    logic        mul_done;
    logic [31:0] mul_result;

    assign is_mul = |e_alu_op[OP_MULHU:OP_MUL];

    exe_mul u_mul (
        .clk       (clk),
        .reset     (reset),
        .flush     (load_en),
        .start     (exe_valid && is_mul),
        .lo_sel    (e_alu_op[OP_MUL]),
        .signed_op (e_alu_op[OP_MULH]),
        .src1      (e_src1),
        .src2      (e_src2),
        .done      (mul_done),
        .result    (mul_result)
    );

    assign alu_result   = is_mul ? mul_result : alu_out;
    assign exe_ready_go = is_mul ? mul_done : mem_ready_go;
`else
    assign is_mul       = 1'b0;
    assign alu_result   = alu_out;
    assign exe_ready_go = mem_ready_go;
`endif

    assign exe_to_mem_bus = {e_pc, e_rkd, alu_result, e_res_from_mem, e_reg_we,
                             e_mem_en, e_mem_we, e_reg_waddr, e_size};

    // a mul in flight also reports as a load-use so ID stalls rather than forwards
    assign exe_to_id_bus = {exe_valid, e_reg_we, e_reg_waddr, alu_result,
                            e_res_from_mem || is_mul};

endmodule

// File: tb/tb_exe_stage.sv
// Scoreboard bench for exe_stage: directed cases then randomized traffic.
module tb_exe_stage;
    import exe_stage_pkg::*;

    localparam int unsigned IW = ID_TO_EXE_BUS_WIDTH;

    logic          clk = 1'b0;
    logic          reset;
    logic          exe_allow_in;
    logic          id_to_exe_valid;
    logic          mem_allow_in;
    logic          exe_to_mem_valid;
    logic [IW-1:0] id_to_exe_bus;
    logic [109:0]  exe_to_mem_bus;
    logic [39:0]   exe_to_id_bus;
    logic          data_sram_req;
    logic          data_sram_wr;
    logic [1:0]    data_sram_size;
    logic [3:0]    data_sram_wstrb;
    logic [31:0]   data_sram_addr;
    logic [31:0]   data_sram_wdata;
    logic          data_sram_addr_ok;

    exe_stage #(
        .ID_TO_EXE_W  (IW),
        .EXE_TO_MEM_W (EXE_TO_MEM_BUS_WIDTH),
        .EXE_TO_ID_W  (EXE_TO_ID_BUS_WIDTH)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .exe_allow_in      (exe_allow_in),
        .id_to_exe_valid   (id_to_exe_valid),
        .mem_allow_in      (mem_allow_in),
        .exe_to_mem_valid  (exe_to_mem_valid),
        .id_to_exe_bus     (id_to_exe_bus),
        .exe_to_mem_bus    (exe_to_mem_bus),
        .exe_to_id_bus     (exe_to_id_bus),
        .data_sram_req     (data_sram_req),
        .data_sram_wr      (data_sram_wr),
        .data_sram_size    (data_sram_size),
        .data_sram_wstrb   (data_sram_wstrb),
        .data_sram_addr    (data_sram_addr),
        .data_sram_wdata   (data_sram_wdata),
        .data_sram_addr_ok (data_sram_addr_ok)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        int unsigned op;
        logic [31:0] src1;
        logic [31:0] src2;
        logic [31:0] rkd;
        logic        rfm;
        logic        rwe;
        logic        men;
        logic [3:0]  mwe;
        logic [4:0]  waddr;
        logic [1:0]  size;
    } ins_t;

    typedef struct {
        logic [109:0] mem_bus;
        logic [39:0]  id_bus;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        wr;
        logic [1:0]  size;
    } req_t;

    exp_t        exp_q[$];
    req_t        req_q[$];
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    bit          env_random = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // reference ALU from the instruction-set definitions
    function automatic logic [31:0] ref_alu(input int unsigned op, input logic [31:0] a, input logic [31:0] b);
        longint          sa = $signed(a);
        longint          sb = $signed(b);
        longint unsigned ua = a;
        longint unsigned ub = b;
        int unsigned     sh = b % 32;
        longint          ps;
        longint unsigned pu;
        ps = sa * sb;
        pu = ua * ub;
        case (op)
            OP_ADD:   return a + b;
            OP_SUB:   return a - b;
            OP_SLT:   return (sa < sb) ? 32'd1 : 32'd0;
            OP_SLTU:  return (ua < ub) ? 32'd1 : 32'd0;
            OP_AND:   return a & b;
            OP_OR:    return a | b;
            OP_NOR:   return ~(a | b);
            OP_XOR:   return a ^ b;
            OP_SLL:   return a << sh;
            OP_SRL:   return a >> sh;
            OP_SRA:   return a[31] ? ~((~a) >> sh) : (a >> sh);
            OP_LUI:   return b;
            OP_MUL:   return ps[31:0];
            OP_MULH:  return ps[63:32];
            OP_MULHU: return pu[63:32];
            default:  return 32'hDEAD_BEEF;
        endcase
    endfunction

    function automatic logic [IW-1:0] pack(input ins_t t);
        logic [ALU_OP_W-1:0] v;
        v = '0;
        v[t.op] = 1'b1;
        return {t.pc, v, t.src1, t.src2, t.rkd, t.rfm, t.rwe, t.men, t.mwe, t.waddr, t.size};
    endfunction

    function automatic exp_t expect_of(input ins_t t);
        exp_t        e;
        logic [31:0] r;
        r = ref_alu(t.op, t.src1, t.src2);
        e.mem_bus = {t.pc, t.rkd, r, t.rfm, t.rwe, t.men, t.mwe, t.waddr, t.size};
        e.id_bus  = {1'b1, t.rwe, t.waddr, r, t.rfm | (t.op >= 12)};
        return e;
    endfunction

    function automatic req_t req_of(input ins_t t);
        req_t q;
        q.addr  = ref_alu(t.op, t.src1, t.src2);
        q.wr    = (t.mwe != 0);
        q.size  = t.size;
        if (!q.wr)                   q.wstrb = 4'h0;
        else if (t.size == 2'b00)    q.wstrb = 4'(1 << (q.addr % 4));
        else                         q.wstrb = 4'hF;
        q.wdata = (t.size == 2'b00) ? t.rkd[7:0] * 32'h0101_0101 : t.rkd;
        return q;
    endfunction

    function automatic ins_t base_ins();
        ins_t t;
        t.pc = 32'h1C00_0000; t.op = OP_ADD; t.src1 = '0; t.src2 = '0; t.rkd = '0;
        t.rfm = 1'b0; t.rwe = 1'b1; t.men = 1'b0; t.mwe = '0; t.waddr = 5'd4; t.size = 2'b10;
        return t;
    endfunction

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 5))
            0:       return 32'h7FFF_FFFF;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    function automatic ins_t rand_ins();
        ins_t t;
        t = base_ins();
        t.pc    = $urandom & 32'hFFFF_FFFC;
        t.rkd   = $urandom;
        t.waddr = 5'($urandom);
        if ($urandom_range(0, 9) < 4) begin
            t.men  = 1'b1;
            t.op   = OP_ADD;
            t.src1 = 32'h1C00_0000 | $urandom_range(0, 255);
            t.src2 = $urandom_range(0, 15);
            t.size = ($urandom % 2) ? 2'b00 : 2'b10;
            if ($urandom % 2) begin
                t.mwe = (t.size == 2'b00) ? 4'b0001 : 4'b1111;
                t.rwe = 1'b0;
            end else begin
                t.rfm = 1'b1;
            end
        end else begin
            t.op   = $urandom_range(0, ALU_OP_W - 1);
            t.src1 = pick_val();
            t.src2 = pick_val();
        end
        return t;
    endfunction

    // present one instruction until EXE accepts it, then record expectations
    task automatic send(input ins_t t);
        int unsigned waited = 0;
        bit          ok = 1'b1;
        id_to_exe_bus   = pack(t);
        id_to_exe_valid = 1'b1;
        @(negedge clk);
        while (!exe_allow_in) begin
            waited++;
            if (waited > 200) begin
                n_cmp++; n_bad++;
                $display("FAIL accept_timeout: got no exe_allow_in after %0d cycles expected acceptance", waited);
                ok = 1'b0;
                break;
            end
            @(negedge clk);
        end
        if (ok) begin
            exp_q.push_back(expect_of(t));
            if (t.men) req_q.push_back(req_of(t));
        end
        @(posedge clk); #1;
        id_to_exe_valid = 1'b0;
    endtask

    task automatic cycle();
        @(posedge clk); #1;
    endtask

    // random SRAM/MEM back-pressure
    initial begin
        forever begin
            @(posedge clk); #1;
            if (env_random) begin
                data_sram_addr_ok = ($urandom % 3) != 0;
                mem_allow_in      = ($urandom % 4) != 0;
            end
        end
    end

    // monitor: pops scoreboard entries whenever the DUT hands something off
    initial begin
        exp_t e;
        req_t r;
        req_t cur;
        req_t held;
        bit   have_held = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                have_held = 1'b0;
                continue;
            end
            if (exe_to_mem_valid && mem_allow_in) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL extra_output: got bus %h expected no output", exe_to_mem_bus);
                end else begin
                    e = exp_q.pop_front();
                    check("exe_to_mem_bus", exe_to_mem_bus, e.mem_bus);
                    check("exe_to_id_bus", exe_to_id_bus, e.id_bus);
                end
            end
            if (data_sram_req) begin
                check("req_needs_mem_allow_in", mem_allow_in, 1'b1);
                cur.addr = data_sram_addr; cur.wdata = data_sram_wdata; cur.wstrb = data_sram_wstrb;
                cur.wr = data_sram_wr; cur.size = data_sram_size;
                if (have_held)
                    check("req_stable", {cur.addr, cur.wdata, cur.wstrb, cur.wr, cur.size},
                          {held.addr, held.wdata, held.wstrb, held.wr, held.size});
                if (data_sram_addr_ok) begin
                    have_held = 1'b0;
                    if (req_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL extra_request: got handshake addr %h expected none", data_sram_addr);
                    end else begin
                        r = req_q.pop_front();
                        check("sram_request", {cur.addr, cur.wdata, cur.wstrb, cur.wr, cur.size},
                              {r.addr, r.wdata, r.wstrb, r.wr, r.size});
                    end
                end else begin
                    held      = cur;
                    have_held = 1'b1;
                end
            end
        end
    end

    initial begin
        ins_t t;
        int unsigned budget;
        reset = 1'b1; id_to_exe_valid = 1'b0; id_to_exe_bus = '0;
        mem_allow_in = 1'b1; data_sram_addr_ok = 1'b0;
        repeat (3) cycle();
        @(negedge clk);
        check("reset_mem_valid", exe_to_mem_valid, 1'b0);
        check("reset_req", data_sram_req, 1'b0);
        check("reset_allow_in", exe_allow_in, 1'b1);
        check("reset_id_valid", exe_to_id_bus[39], 1'b0);
        cycle();
        reset = 1'b0;

        // add with signed overflow
        t = base_ins(); t.src1 = 32'h7FFF_FFFF; t.src2 = 32'd1;
        send(t);
        @(negedge clk);
        check("add_valid_next", exe_to_mem_valid, 1'b1);
        check("add_result", exe_to_mem_bus[45:14], 32'h8000_0000);
        check("add_no_req", data_sram_req, 1'b0);
        cycle();

        // load stalled by addr_ok for three cycles
        t = base_ins(); t.men = 1'b1; t.rfm = 1'b1; t.src1 = 32'h1C00_0000; t.src2 = 32'h10;
        send(t);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("lw_req_wait", data_sram_req, 1'b1);
            check("lw_addr_wait", data_sram_addr, 32'h1C00_0010);
            check("lw_allow_in_wait", exe_allow_in, 1'b0);
            cycle();
        end
        data_sram_addr_ok = 1'b1;
        @(negedge clk);
        check("lw_valid_on_ok", exe_to_mem_valid, 1'b1);
        check("lw_wstrb", data_sram_wstrb, 4'h0);
        cycle();
        data_sram_addr_ok = 1'b0;
        @(negedge clk);
        check("lw_req_drops", data_sram_req, 1'b0);
        cycle();

        // byte store at offset 3
        data_sram_addr_ok = 1'b1;
        t = base_ins(); t.men = 1'b1; t.rwe = 1'b0; t.mwe = 4'b0001; t.size = 2'b00;
        t.src1 = 32'h1C00_0000; t.src2 = 32'h3; t.rkd = 32'h1234_5678;
        send(t);
        @(negedge clk);
        check("stb_req", data_sram_req, 1'b1);
        check("stb_wstrb", data_sram_wstrb, 4'b1000);
        check("stb_wdata", data_sram_wdata, 32'h7878_7878);
        check("stb_size", data_sram_size, 2'b00);
        check("stb_wr", data_sram_wr, 1'b1);
        cycle();

        // load while MEM is blocked
        mem_allow_in = 1'b0;
        t = base_ins(); t.men = 1'b1; t.rfm = 1'b1; t.src1 = 32'h1C00_0040;
        send(t);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("blocked_no_req", data_sram_req, 1'b0);
            check("blocked_no_valid", exe_to_mem_valid, 1'b0);
            cycle();
        end
        mem_allow_in = 1'b1;
        @(negedge clk);
        check("unblocked_req", data_sram_req, 1'b1);
        check("unblocked_valid", exe_to_mem_valid, 1'b1);
        cycle();
        @(negedge clk);
        check("unblocked_single_req", data_sram_req, 1'b0);
        cycle();

        // reset during an outstanding request
        data_sram_addr_ok = 1'b0;
        t = base_ins(); t.men = 1'b1; t.rfm = 1'b1; t.src1 = 32'h1C00_0080;
        send(t);
        @(negedge clk);
        check("pre_reset_req", data_sram_req, 1'b1);
        cycle();
        reset = 1'b1;
        cycle();
        @(negedge clk);
        check("reset_mid_req", data_sram_req, 1'b0);
        check("reset_mid_id_valid", exe_to_id_bus[39], 1'b0);
        check("reset_mid_mem_valid", exe_to_mem_valid, 1'b0);
        exp_q.delete();
        req_q.delete();
        cycle();
        reset = 1'b0;
        data_sram_addr_ok = 1'b1;

`ifdef EXE_MUL_EN
        // two-cycle multiply
        t = base_ins(); t.op = OP_MUL; t.src1 = 32'hFFFF_FFFF; t.src2 = 32'd2;
        send(t);
        @(negedge clk);
        check("mul_first_cycle", exe_to_mem_valid, 1'b0);
        check("mul_stall_flag", exe_to_id_bus[0], 1'b1);
        cycle();
        @(negedge clk);
        check("mul_second_cycle", exe_to_mem_valid, 1'b1);
        check("mul_result", exe_to_mem_bus[45:14], 32'hFFFF_FFFE);
        cycle();
        t.op = OP_MULHU;
        send(t);
        @(negedge clk);
        check("mulhu_first_cycle", exe_to_mem_valid, 1'b0);
        cycle();
        @(negedge clk);
        check("mulhu_second_cycle", exe_to_mem_valid, 1'b1);
        check("mulhu_result", exe_to_mem_bus[45:14], 32'h0000_0001);
        cycle();
`endif

        // back-to-back loads with addr_ok every cycle
        for (int i = 0; i < 4; i++) begin
            t = base_ins(); t.men = 1'b1; t.rfm = 1'b1; t.src1 = 32'h1C00_0100 + 32'(4 * i);
            send(t);
        end
        repeat (3) cycle();

        // randomized traffic
        env_random = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom % 4 == 0) cycle();
            send(rand_ins());
        end
        budget = 0;
        while ((exp_q.size() != 0 || req_q.size() != 0) && budget < 500) begin
            cycle();
            budget++;
        end
        check("drain_outputs", exp_q.size(), 0);
        check("drain_requests", req_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
